// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer stimulus blocks: FSM encoding,
// LFSR seed/taps and the reaction-time width.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DELAY = 2'd1,
    ARMED      = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 15,13,12,10 of a left-shifting register, i.e. taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

  localparam int REACT_W = 14;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every cycle out of reset.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/led_stim_seq.sv
// Reaction-timer stimulus sequencer: random delay, LED pick, ms reaction timing.
// Define LED_STIM_BEST_EN to add the best_ms output (fastest hit since reset).
module led_stim_seq
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int TIMEOUT_MS   = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         btn,
  output logic [1:0]         led_sel,
  output logic               led_on,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic               early,
  output logic               timeout,
  output logic [REACT_W-1:0] react_ms
`ifdef LED_STIM_BEST_EN
  ,
  output logic [REACT_W-1:0] best_ms
`endif
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DLY_W  = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));

  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the top two bits and the delay bits are consumed.
  assign lfsr_unused = ^lfsr_q;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [1:0]           led_sel_q, led_sel_d;
  logic                 led_on_q, led_on_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hit_q, hit_d;
  logic                 early_q, early_d;
  logic                 timeout_q, timeout_d;
  logic [REACT_W-1:0]   react_q, react_d;
  logic                 tick;

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    dly_d      = dly_q;
    led_sel_d  = led_sel_q;
    hit_d      = hit_q;
    early_d    = early_q;
    timeout_d  = timeout_q;
    react_d    = react_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          led_sel_d  = lfsr_q[15:14];
          dly_d      = DLY_W'(DELAY_MIN_MS) + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
          hit_d      = 1'b0;
          early_d    = 1'b0;
          timeout_d  = 1'b0;
          react_d    = '0;
          tick_cnt_d = '0;
          state_d    = WAIT_DELAY;
        end
      end
      WAIT_DELAY: begin
        if (btn != 4'b0000) begin
          early_d = 1'b1;
          state_d = DONE;
        end else if (tick) begin
          dly_d = dly_q - DLY_W'(1);
          // The divider wraps to zero on this tick, so ARMED starts a fresh ms.
          if (dly_q <= DLY_W'(1)) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (tick) begin
          react_d = react_q + REACT_W'(1);
        end
        // A press beats a timeout landing on the same tick.
        if (btn != 4'b0000) begin
          hit_d   = (btn == onehot4(led_sel_q));
          state_d = DONE;
        end else if (react_d == REACT_W'(TIMEOUT_MS)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    led_on_d = (state_d == ARMED);
    busy_d   = (state_d == WAIT_DELAY) || (state_d == ARMED);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      dly_q      <= '0;
      led_sel_q  <= 2'b00;
      led_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
      react_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dly_q      <= dly_d;
      led_sel_q  <= led_sel_d;
      led_on_q   <= led_on_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      early_q    <= early_d;
      timeout_q  <= timeout_d;
      react_q    <= react_d;
    end
  end

  assign led_sel  = led_sel_q;
  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign early    = early_q;
  assign timeout  = timeout_q;
  assign react_ms = react_q;

`ifdef LED_STIM_BEST_EN
  logic [REACT_W-1:0] best_q, best_d;

  // Updated while in DONE, when hit/react_ms already hold the finished round.
  always_comb begin
    best_d = best_q;
    if ((state_q == DONE) && hit_q && (react_q < best_q)) begin
      best_d = react_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= {REACT_W{1'b1}};
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`else
  // No best-time tracking in this build.
`endif

endmodule

// File: tb/tb_led_stim_seq.sv
// Directed bench for led_stim_seq with a small tick divider and short delays.
module tb_led_stim_seq;
  import reaction_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DMIN     = 2;
  localparam int DBITS    = 2;
  localparam int TMO      = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic [1:0]  led_sel;
  logic        led_on, busy, done, hit, early, timeout;
  logic [13:0] react_ms;
`ifdef LED_STIM_BEST_EN
  logic [13:0] best_ms;
`endif

  led_stim_seq #(
    .TICK_DIV     (TICK_DIV),
    .DELAY_MIN_MS (DMIN),
    .DELAY_BITS   (DBITS),
    .TIMEOUT_MS   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .btn      (btn),
    .led_sel  (led_sel),
    .led_on   (led_on),
    .busy     (busy),
    .done     (done),
    .hit      (hit),
    .early    (early),
    .timeout  (timeout),
    .react_ms (react_ms)
`ifdef LED_STIM_BEST_EN
    ,
    .best_ms  (best_ms)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR used to predict LED and delay of rounds started without a reset.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts a round from IDLE and checks that led_on rises exactly n cycles later.
  task automatic arm(input string tag, input logic [1:0] sel, input int n, input bit restart);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".led_on_low"}, 16'(led_on), 16'd0);
      chk({tag, ".busy_wait"}, 16'(busy), 16'd1);
      start = (restart && i == 3);
      step();
    end
    start = 1'b0;
    chk({tag, ".led_on_rise"}, 16'(led_on), 16'd1);
    chk({tag, ".busy_armed"}, 16'(busy), 16'd1);
    chk({tag, ".led_sel"}, 16'(led_sel), 16'(sel));
  endtask

  task automatic arm_model(input string tag, output logic [1:0] sel);
    int n;
    sel = lfsr_m[15:14];
    n   = (DMIN + int'(lfsr_m[DBITS-1:0])) * TICK_DIV;
    arm(tag, sel, n, 1'b0);
  endtask

  task automatic press_after(input string tag, input int k, input logic [3:0] b);
    repeat (4 * k) step();
    chk({tag, ".react_pre"}, 16'(react_ms), 16'(k));
    chk({tag, ".no_done_pre"}, 16'(done), 16'd0);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  task automatic chk_done(input string tag, input logic h, input logic e, input logic t,
                          input logic [13:0] r);
    $display("round %s: sel=%0d hit=%0b early=%0b timeout=%0b react_ms=%0d",
             tag, led_sel, hit, early, timeout, react_ms);
    chk({tag, ".done"}, 16'(done), 16'd1);
    chk({tag, ".led_on_fall"}, 16'(led_on), 16'd0);
    chk({tag, ".busy_fall"}, 16'(busy), 16'd0);
    chk({tag, ".hit"}, 16'(hit), 16'(h));
    chk({tag, ".early"}, 16'(early), 16'(e));
    chk({tag, ".timeout"}, 16'(timeout), 16'(t));
    chk({tag, ".react_ms"}, 16'(react_ms), 16'(r));
    step();
    chk({tag, ".done_one_cycle"}, 16'(done), 16'd0);
    chk({tag, ".hit_hold"}, 16'(hit), 16'(h));
    chk({tag, ".react_hold"}, 16'(react_ms), 16'(r));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic early_round(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    btn = 4'b1000;
    step();
    btn = 4'b0000;
    chk_done(tag, 1'b0, 1'b1, 1'b0, 14'd0);
    for (int i = 0; i < 12; i++) begin
      chk({tag, ".led_stays_off"}, 16'(led_on), 16'd0);
      step();
    end
  endtask

  initial begin
    logic [1:0] sel;

    // Reset values
    @(negedge clk);
    step();
    step();
    chk("rst.led_sel", 16'(led_sel), 16'd0);
    chk("rst.led_on", 16'(led_on), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.hit", 16'(hit), 16'd0);
    chk("rst.early", 16'(early), 16'd0);
    chk("rst.timeout", 16'(timeout), 16'd0);
    chk("rst.react_ms", 16'(react_ms), 16'd0);
`ifdef LED_STIM_BEST_EN
    chk("rst.best_ms", 16'(best_ms), 16'h3FFF);
`endif

    // Seed round: L=ACE1 -> led_sel=2, delay=3 ms -> 12 cycles; then hit after 5 ticks
    rst = 1'b0;
    arm("seed", 2'b10, 12, 1'b0);
    press_after("seed", 5, 4'b0100);
    chk_done("seed_hit", 1'b1, 1'b0, 1'b0, 14'd5);

    // Wrong single button
    reset_dut();
    arm("wrong", 2'b10, 12, 1'b0);
    press_after("wrong", 2, 4'b0001);
    chk_done("wrong", 1'b0, 1'b0, 1'b0, 14'd2);

    // Multiple buttons including the correct one, on the first ARMED cycle
    reset_dut();
    arm("multi", 2'b10, 12, 1'b0);
    press_after("multi", 0, 4'b0101);
    chk_done("multi", 1'b0, 1'b0, 1'b0, 14'd0);

    // Early press during the delay
    reset_dut();
    early_round("early");

    // Timeout with no press
    reset_dut();
    arm("tmo", 2'b10, 12, 1'b0);
    repeat (79) step();
    chk("tmo.react_19", 16'(react_ms), 16'd19);
    chk("tmo.no_done_yet", 16'(done), 16'd0);
    step();
    chk_done("timeout", 1'b0, 1'b0, 1'b1, 14'd20);

    // Correct press on the 20th tick cycle: press beats timeout
    reset_dut();
    arm("tie", 2'b10, 12, 1'b0);
    repeat (79) step();
    chk("tie.react_19", 16'(react_ms), 16'd19);
    btn = 4'b0100;
    step();
    btn = 4'b0000;
    chk_done("tie", 1'b1, 1'b0, 1'b0, 14'd20);

    // Reset while ARMED: everything clears, no done pulse, LFSR reseeded
    reset_dut();
    arm("rst_armed", 2'b10, 12, 1'b0);
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("rst_armed.led_on", 16'(led_on), 16'd0);
    chk("rst_armed.led_sel", 16'(led_sel), 16'd0);
    chk("rst_armed.busy", 16'(busy), 16'd0);
    chk("rst_armed.done", 16'(done), 16'd0);
    chk("rst_armed.react_ms", 16'(react_ms), 16'd0);
    rst = 1'b0;
    // Second start during WAIT_DELAY must not restart the delay
    arm("restart_ignored", 2'b10, 12, 1'b1);
    chk("rst_armed.no_done", 16'(done), 16'd0);
    press_after("restart_ignored", 3, 4'b0100);
    chk_done("restart_ignored", 1'b1, 1'b0, 1'b0, 14'd3);

    // Back-to-back rounds with LFSR-predicted LED/delay: hits of 7, 5, 9 ms
    reset_dut();
    repeat (3) step();
    arm_model("m7", sel);
    press_after("m7", 7, 4'b0001 << sel);
    chk_done("m7", 1'b1, 1'b0, 1'b0, 14'd7);
`ifdef LED_STIM_BEST_EN
    chk("best.after7", 16'(best_ms), 16'd7);
`endif
    repeat (5) step();
    arm_model("m5", sel);
    press_after("m5", 5, 4'b0001 << sel);
    chk_done("m5", 1'b1, 1'b0, 1'b0, 14'd5);
    repeat (2) step();
    arm_model("m9", sel);
    press_after("m9", 9, 4'b0001 << sel);
    chk_done("m9", 1'b1, 1'b0, 1'b0, 14'd9);
`ifdef LED_STIM_BEST_EN
    chk("best.after9", 16'(best_ms), 16'd5);
`endif
    early_round("m_early");
`ifdef LED_STIM_BEST_EN
    chk("best.after_early", 16'(best_ms), 16'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
